// File: rtl/object_state_renderer.sv
// rtl/object_state_renderer.sv - latches one object state per frame and hit-tests VGA pixels
// Optional TILE_WRAP_EN: the object repeats vertically as a scrolling background tile.
module object_state_renderer #(
   parameter int FIELD_W  = 11,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    frame_start,
   input  logic [0:4][0:FIELD_W-1] state_in,
   input  logic [FIELD_W-1:0]      pixelX,
   input  logic [FIELD_W-1:0]      pixelY,
   output logic                    drawingRequest,
   output logic [FIELD_W-1:0]      offsetX,
   output logic [FIELD_W-1:0]      offsetY,
   output logic [FIELD_W-1:0]      img_id,
   output logic                    state_valid,
   output logic                    busy
);
   localparam int DW = FIELD_W + 1;
   localparam logic [FIELD_W-1:0] SCR_W = FIELD_W'(SCREEN_W);
   localparam logic [FIELD_W-1:0] SCR_H = FIELD_W'(SCREEN_H);

   typedef enum logic [1:0] {EMPTY, LOAD, NORM, READY} state_t;
   state_t state, state_next;

   logic [FIELD_W-1:0] sh_img, sh_x, sh_y, sh_w, sh_h;
   logic [DW-1:0]      dx, dy;
   logic               on_screen;
   logic               h_ok, v_ok, hit;
   logic [FIELD_W-1:0] row_off;

`ifdef TILE_WRAP_EN
   logic signed [DW-1:0] acc;
   logic signed [DW-1:0] h_ext;
   logic                 acc_in_range;
   logic [FIELD_W-1:0]   rowcnt, row_q, rowcnt_inc;

   assign h_ext        = $signed({1'b0, sh_h});
   assign acc_in_range = !acc[DW-1] && (acc < h_ext);
   assign rowcnt_inc   = rowcnt + 1'b1;
`endif

   always_comb begin
      state_next = state;
      case (state)
         EMPTY: state_next = EMPTY;
         LOAD: begin
            if (sh_w == '0 || sh_h == '0)
               state_next = EMPTY;
            else
`ifdef TILE_WRAP_EN
               state_next = NORM;
`else
               state_next = READY;
`endif
         end
         NORM: begin
`ifdef TILE_WRAP_EN
            if (acc_in_range)
               state_next = READY;
`else
            state_next = READY;
`endif
         end
         READY: state_next = READY;
      endcase
      // a new frame always wins, so an unfinished NORM never publishes stale state
      if (frame_start)
         state_next = LOAD;
   end

   assign state_valid = (state == READY);
   assign busy        = (state == LOAD) || (state == NORM);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state  <= EMPTY;
         sh_img <= '0;
         sh_x   <= '0;
         sh_y   <= '0;
         sh_w   <= '0;
         sh_h   <= '0;
         img_id <= '0;
      end else begin
         state <= state_next;
         if (frame_start) begin
            sh_img <= state_in[0];
            sh_x   <= state_in[1];
            sh_y   <= state_in[2];
            sh_w   <= state_in[3];
            sh_h   <= state_in[4];
         end
         if (state_next == READY && state != READY)
            img_id <= sh_img;
      end
   end

`ifdef TILE_WRAP_EN
   // acc settles to (-y) mod height one add/subtract per cycle during vblank
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc    <= '0;
         rowcnt <= '0;
         row_q  <= '0;
      end else begin
         if (state == LOAD && state_next == NORM)
            acc <= -$signed({sh_y[FIELD_W-1], sh_y});
         else if (state == NORM) begin
            if (acc[DW-1])
               acc <= acc + h_ext;
            else if (acc >= h_ext)
               acc <= acc - h_ext;
         end
         row_q <= pixelY;
         if (pixelY != row_q) begin
            if (pixelY == '0)
               rowcnt <= acc[FIELD_W-1:0];
            else if (rowcnt_inc >= sh_h)
               rowcnt <= '0;
            else
               rowcnt <= rowcnt_inc;
         end
      end
   end
`endif

   // stage 1: signed distances from the box origin
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dx        <= '0;
         dy        <= '0;
         on_screen <= 1'b0;
      end else begin
         dx        <= {1'b0, pixelX} - {sh_x[FIELD_W-1], sh_x};
         dy        <= {1'b0, pixelY} - {sh_y[FIELD_W-1], sh_y};
         on_screen <= (pixelX < SCR_W) && (pixelY < SCR_H);
      end
   end

   assign h_ok = !dx[DW-1] && (dx[FIELD_W-1:0] < sh_w);
   assign v_ok = !dy[DW-1] && (dy[FIELD_W-1:0] < sh_h);
`ifdef TILE_WRAP_EN
   assign hit     = h_ok && on_screen && state_valid;
   assign row_off = rowcnt;
`else
   assign hit     = h_ok && v_ok && on_screen && state_valid;
   assign row_off = dy[FIELD_W-1:0];
`endif

   // stage 2: registered outputs, offsets zeroed outside the box
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         drawingRequest <= 1'b0;
         offsetX        <= '0;
         offsetY        <= '0;
      end else begin
         drawingRequest <= hit;
         offsetX        <= hit ? dx[FIELD_W-1:0] : '0;
         offsetY        <= hit ? row_off : '0;
      end
   end
endmodule
